// File: rtl/bus_protocol_if.sv
// Peripheral bus used by pwm_bank: a single-cycle address/strobe port with
// combinational read data and error, plus a stall line the peripheral may drive.
interface bus_protocol_if;
    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    modport cpu (
        output addr, wen, ren, wdata,
        input  rdata, error, request_stall
    );

    modport peripheral_vital (
        input  addr, wen, ren, wdata,
        output rdata, error, request_stall
    );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM with shadowed PERIOD/DUTY that reload only at period boundaries.
// Define PWM_CENTER_ALIGN_EN to build the CTRL.CA up/down (center-aligned) counter.
module pwm_bank #(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                     CLK,
    input  logic                     nRST,
    output logic [NUM_CHANNELS-1:0]  pwm_out,
    bus_protocol_if.peripheral_vital busif
);
    localparam logic [31:0]          MAP_END = 32'(NUM_CHANNELS * 16);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    function automatic logic duty_level(input logic [CNT_WIDTH-1:0] cnt,
                                        input logic [CNT_WIDTH-1:0] per,
                                        input logic [CNT_WIDTH-1:0] duty);
        return (per != '0) && (cnt < duty);
    endfunction

    logic                                   mapped;
    logic [3:0]                             sel_ch;
    logic [1:0]                             sel_reg;
    logic                                   wr_ok;
    logic [CNT_WIDTH-1:0]                   wdata_cnt;
    logic [NUM_CHANNELS-1:0][CNT_WIDTH-1:0] rb_period;
    logic [NUM_CHANNELS-1:0][CNT_WIDTH-1:0] rb_duty;
    logic [NUM_CHANNELS-1:0][CNT_WIDTH-1:0] rb_count;
    logic [NUM_CHANNELS-1:0][2:0]           rb_ctrl;
    logic                                   unused_bus;

    assign mapped    = busif.addr < MAP_END;
    assign sel_ch    = busif.addr[7:4];
    assign sel_reg   = busif.addr[3:2];
    assign wdata_cnt = busif.wdata[CNT_WIDTH-1:0];
    // COUNT is read-only: a write there is flagged and dropped
    assign wr_ok     = busif.wen && mapped && (sel_reg != 2'd3);
    assign busif.error = ((busif.wen || busif.ren) && !mapped) ||
                         (busif.wen && mapped && (sel_reg == 2'd3));
    assign busif.request_stall = 1'b0;
    assign unused_bus = ^{busif.addr[1:0], busif.wdata};

    always_comb begin
        busif.rdata = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (busif.ren && mapped && (sel_ch == 4'(c))) begin
                case (sel_reg)
                    2'd0:    busif.rdata = 32'(rb_period[c]);
                    2'd1:    busif.rdata = 32'(rb_duty[c]);
                    2'd2:    busif.rdata = {29'd0, rb_ctrl[c]};
                    default: busif.rdata = 32'(rb_count[c]);
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [CNT_WIDTH-1:0] shadow_period;
        logic [CNT_WIDTH-1:0] shadow_duty;
        logic [CNT_WIDTH-1:0] act_period;
        logic [CNT_WIDTH-1:0] act_duty;
        logic [CNT_WIDTH-1:0] cnt_p0;
        logic [CNT_WIDTH-1:0] cnt_nxt;
        logic                 en;
        logic                 inv;
        logic                 bnd;
        logic                 raw_p0;
        logic                 pwm_p1;
        logic                 ch_wr;
        logic                 ca_rb;
`ifdef PWM_CENTER_ALIGN_EN
        logic                 ca;
        logic                 act_ca;
        logic                 dir_down;
        logic                 dir_nxt;
        assign ca_rb = ca;
`else
        assign ca_rb = 1'b0;
`endif

        assign ch_wr        = wr_ok && (sel_ch == 4'(g));
        assign raw_p0       = duty_level(cnt_p0, act_period, act_duty);
        assign pwm_out[g]   = pwm_p1;
        assign rb_period[g] = shadow_period;
        assign rb_duty[g]   = shadow_duty;
        assign rb_count[g]  = cnt_p0;
        assign rb_ctrl[g]   = {ca_rb, inv, en};

        always_comb begin
            cnt_nxt = '0;
            bnd     = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_nxt = 1'b0;
`endif
            if (act_period == '0) begin
                bnd = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
            end else if (act_ca) begin
                // Turn around at P; the period ends on the down-step from 1 to 0
                if (!dir_down) begin
                    if (cnt_p0 >= act_period) begin
                        cnt_nxt = act_period - ONE;
                        if (act_period == ONE) bnd = 1'b1;
                        else                   dir_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_p0 + ONE;
                    end
                end else if (cnt_p0 <= ONE) begin
                    bnd = 1'b1;
                end else begin
                    cnt_nxt = cnt_p0 - ONE;
                    dir_nxt = 1'b1;
                end
`endif
            end else if (cnt_p0 >= act_period - ONE) begin
                bnd = 1'b1;
            end else begin
                cnt_nxt = cnt_p0 + ONE;
            end
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                shadow_period <= '0;
                shadow_duty   <= '0;
                act_period    <= '0;
                act_duty      <= '0;
                cnt_p0        <= '0;
                en            <= 1'b0;
                inv           <= 1'b0;
                pwm_p1        <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
                ca            <= 1'b0;
                act_ca        <= 1'b0;
                dir_down      <= 1'b0;
`endif
            end else begin
                if (ch_wr) begin
                    case (sel_reg)
                        2'd0:    shadow_period <= wdata_cnt;
                        2'd1:    shadow_duty   <= wdata_cnt;
                        default: begin
                            en  <= busif.wdata[0];
                            inv <= busif.wdata[1];
`ifdef PWM_CENTER_ALIGN_EN
                            ca  <= busif.wdata[2];
`endif
                        end
                    endcase
                end
                // stage p0 -> p1: the pad level lags the counter by one cycle
                if (!en) begin
                    cnt_p0     <= '0;
                    act_period <= shadow_period;
                    act_duty   <= shadow_duty;
                    pwm_p1     <= inv;
`ifdef PWM_CENTER_ALIGN_EN
                    act_ca     <= ca;
                    dir_down   <= 1'b0;
`endif
                end else begin
                    cnt_p0 <= cnt_nxt;
                    pwm_p1 <= raw_p0 ^ inv;
`ifdef PWM_CENTER_ALIGN_EN
                    dir_down <= dir_nxt;
`endif
                    if (bnd) begin
                        act_period <= shadow_period;
                        act_duty   <= shadow_duty;
`ifdef PWM_CENTER_ALIGN_EN
                        act_ca     <= ca;
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: a phase-based channel model is compared every cycle,
// and hand-computed literal expectations pin the model to the intended behaviour.
module tb_pwm_bank;
    localparam int NCH = 4;
    localparam int CW  = 16;

    logic           CLK  = 1'b0;
    logic           nRST = 1'b1;
    logic [NCH-1:0] pwm_out;

    bus_protocol_if busif ();

    pwm_bank #(.NUM_CHANNELS(NCH), .CNT_WIDTH(CW)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .pwm_out(pwm_out),
        .busif  (busif)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each channel walks a phase 0..L-1, L = P (edge) or 2P (center), L=1 when P=0
    int m_sp[NCH], m_sd[NCH], m_ap[NCH], m_ad[NCH], m_phase[NCH];
    bit m_en[NCH], m_inv[NCH], m_ca[NCH], m_aca[NCH], m_pwm[NCH];

    function automatic int m_count(input int c);
        if (m_ap[c] == 0) return 0;
        if (m_aca[c] && m_phase[c] > m_ap[c]) return 2 * m_ap[c] - m_phase[c];
        return m_phase[c];
    endfunction

    function automatic int m_len(input int c);
        if (m_ap[c] == 0) return 1;
        return m_aca[c] ? 2 * m_ap[c] : m_ap[c];
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int c = 0; c < NCH; c++) begin
                m_sp[c] <= 0; m_sd[c] <= 0; m_ap[c] <= 0; m_ad[c] <= 0; m_phase[c] <= 0;
                m_en[c] <= 0; m_inv[c] <= 0; m_ca[c] <= 0; m_aca[c] <= 0; m_pwm[c] <= 0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (!m_en[c]) begin
                    m_pwm[c]   <= m_inv[c];
                    m_phase[c] <= 0;
                    m_ap[c]    <= m_sp[c];
                    m_ad[c]    <= m_sd[c];
                    m_aca[c]   <= m_ca[c];
                end else begin
                    m_pwm[c] <= ((m_ap[c] != 0) && (m_count(c) < m_ad[c])) ^ m_inv[c];
                    if (m_phase[c] == m_len(c) - 1) begin
                        m_phase[c] <= 0;
                        m_ap[c]    <= m_sp[c];
                        m_ad[c]    <= m_sd[c];
                        m_aca[c]   <= m_ca[c];
                    end else begin
                        m_phase[c] <= m_phase[c] + 1;
                    end
                end
            end
            if (busif.wen && busif.addr < 32'(NCH * 16)) begin
                case (busif.addr[3:2])
                    2'd0: m_sp[busif.addr[5:4]] <= int'(busif.wdata[CW-1:0]);
                    2'd1: m_sd[busif.addr[5:4]] <= int'(busif.wdata[CW-1:0]);
                    2'd2: begin
                        m_en[busif.addr[5:4]]  <= busif.wdata[0];
                        m_inv[busif.addr[5:4]] <= busif.wdata[1];
`ifdef PWM_CENTER_ALIGN_EN
                        m_ca[busif.addr[5:4]]  <= busif.wdata[2];
`else
                        m_ca[busif.addr[5:4]]  <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [NCH-1:0] exp_pwm();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_pwm[c];
        return v;
    endfunction

    function automatic logic [31:0] exp_rdata();
        int c;
        if (!busif.ren || busif.addr >= 32'(NCH * 16)) return 32'd0;
        c = int'(busif.addr[5:4]);
        case (busif.addr[3:2])
            2'd0:    return 32'(m_sp[c]);
            2'd1:    return 32'(m_sd[c]);
            2'd2:    return {29'd0, m_ca[c], m_inv[c], m_en[c]};
            default: return 32'(m_count(c));
        endcase
    endfunction

    function automatic logic exp_error();
        if (!(busif.wen || busif.ren)) return 1'b0;
        if (busif.addr >= 32'(NCH * 16)) return 1'b1;
        return busif.wen && (busif.addr[3:2] == 2'd3);
    endfunction

    always @(negedge CLK) begin
        check("pwm_out", 64'(pwm_out), 64'(exp_pwm()));
        check("rdata",   64'(busif.rdata), 64'(exp_rdata()));
        check("error",   64'(busif.error), 64'(exp_error()));
    end

    task automatic bus(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdv, output logic erv);
        busif.wen = w; busif.ren = r; busif.addr = a; busif.wdata = d;
        @(negedge CLK);
        rdv = busif.rdata;
        erv = busif.error;
        @(posedge CLK); #1;
        busif.wen = 1'b0; busif.ren = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rdv; logic erv;
        bus(1'b1, 1'b0, a, d, rdv, erv);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        logic erv;
        bus(1'b0, 1'b1, a, 32'd0, v, erv);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic sample(input int ch, input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge CLK);
            ones += int'(pwm_out[ch]);
        end
        @(posedge CLK); #1;
    endtask

    task automatic sync_count(input logic [31:0] a, input int target, input string name);
        logic [31:0] v;
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rd(a, v);
            if (v == 32'(target)) begin ok = 1'b1; break; end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    logic [31:0] v, v2;
    logic        e;
    int          ones;
    int          seq_tbl[8];

    initial begin
        busif.wen = 1'b0; busif.ren = 1'b0; busif.addr = '0; busif.wdata = '0;
        #1 nRST = 1'b0;
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        check("reset_pwm", 64'(pwm_out), 64'd0);
        check("stall_tied_low", 64'(busif.request_stall), 64'd0);

        // Edge mode: P=10, D=3 on ch0
        wr(32'h00, 32'd10); wr(32'h04, 32'd3); wr(32'h08, 32'd1);
        sample(0, 20, ones);
        check("edge_high_count", 64'(ones), 64'd6);
        rd(32'h0C, v); rd(32'h0C, v2);
        check("edge_count_a", 64'(v), 64'd0);
        check("edge_count_b", 64'(v2), 64'd1);

        // Shadow: D=7 mid-period, then D=5 on the wrap cycle
        sync_count(32'h0C, 3, "sync_cnt3");
        wr(32'h04, 32'd7);
        sample(0, 15, ones);
        check("shadow_mid_write", 64'(ones), 64'd7);
        sync_count(32'h0C, 8, "sync_cnt8");
        wr(32'h04, 32'd5);
        sample(0, 11, ones);
        check("shadow_wrap_old", 64'(ones), 64'd7);
        sample(0, 9, ones);
        check("shadow_wrap_new", 64'(ones), 64'd5);

        // Corners on ch1
        wr(32'h10, 32'd10); wr(32'h14, 32'd0); wr(32'h18, 32'd1);
        sample(1, 12, ones);
        check("duty0_low", 64'(ones), 64'd0);
        wr(32'h14, 32'd12); idle(12);
        sample(1, 10, ones);
        check("duty_ge_p_high", 64'(ones), 64'd10);
        wr(32'h18, 32'd3); idle(1);
        sample(1, 10, ones);
        check("inv_duty_ge_p", 64'(ones), 64'd0);
        wr(32'h10, 32'd0); idle(12);
        sample(1, 10, ones);
        check("inv_p0", 64'(ones), 64'd10);
        wr(32'h18, 32'd2); idle(2);
        sample(1, 5, ones);
        check("idle_inv_high", 64'(ones), 64'd5);
        wr(32'h18, 32'd0); idle(2);
        sample(1, 5, ones);
        check("idle_low", 64'(ones), 64'd0);

        // Bus errors and readback truncation
        bus(1'b1, 1'b0, 32'h40, 32'd5, v, e);
        check("err_wr_unmapped", 64'(e), 64'd1);
        bus(1'b0, 1'b1, 32'h40, 32'd0, v, e);
        check("err_rd_unmapped", 64'(e), 64'd1);
        check("rd_unmapped_zero", 64'(v), 64'd0);
        bus(1'b1, 1'b0, 32'h0C, 32'd7, v, e);
        check("err_wr_count", 64'(e), 64'd1);
        rd(32'h00, v);
        check("ch0_period_kept", 64'(v), 64'd10);
        wr(32'h10, 32'h0001_0005);
        bus(1'b0, 1'b1, 32'h10, 32'd0, v, e);
        check("trunc_period", 64'(v), 64'h5);
        check("legal_rd_no_err", 64'(e), 64'd0);

        // EN 1->0 mid-period on ch0
        wr(32'h08, 32'd0); idle(1);
        rd(32'h0C, v);
        check("disable_count0", 64'(v), 64'd0);
        check("disable_pwm_low", 64'(pwm_out[0]), 64'd0);

        // Center-aligned on ch2 (edge-aligned when the option is absent)
        wr(32'h20, 32'd4); wr(32'h24, 32'd2); wr(32'h28, 32'd4); wr(32'h28, 32'd5);
        rd(32'h28, v);
`ifdef PWM_CENTER_ALIGN_EN
        check("ctrl_ca_rb", 64'(v), 64'd5);
        seq_tbl = '{1, 2, 3, 4, 3, 2, 1, 0};
`else
        check("ctrl_ca_rb", 64'(v), 64'd1);
        seq_tbl = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif
        sync_count(32'h2C, 0, "sync_ch2");
        for (int i = 0; i < 8; i++) begin
            rd(32'h2C, v);
            check($sformatf("ch2_count_%0d", i), 64'(v), 64'(seq_tbl[i]));
        end
        sample(2, 8, ones);
`ifdef PWM_CENTER_ALIGN_EN
        check("center_high_count", 64'(ones), 64'd3);
`else
        check("center_high_count", 64'(ones), 64'd4);
`endif

        // Asynchronous reset mid-run
        #2 nRST = 1'b0;
        #1 check("async_reset_pwm", 64'(pwm_out), 64'd0);
        bus(1'b0, 1'b1, 32'h20, 32'd0, v, e);
        check("reset_rd_period", 64'(v), 64'd0);
        check("reset_rd_err", 64'(e), 64'd0);
        bus(1'b0, 1'b1, 32'h28, 32'd0, v, e);
        check("reset_rd_ctrl", 64'(v), 64'd0);
        nRST = 1'b1;
        rd(32'h24, v);
        check("post_reset_duty", 64'(v), 64'd0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
